// File: rtl/divisor_fixed_pkg.sv
// Shared definitions for the fixed-point divider.
// Holds the operand/result formats, the derived numerator shift and width,
// the FSM state encoding and the saturated result limits.
package divisor_fixed_pkg;

    // Operand and result formats: total bits / fractional bits.
    localparam int NBA  = 16;
    localparam int NBFA = 14;
    localparam int NBB  = 12;
    localparam int NBFB = 11;
    localparam int NBQ  = 11;
    localparam int NBFQ = 10;

    // The dividend is pre-shifted so that the integer quotient carries
    // exactly NBFQ fractional bits.
    localparam int SH    = NBFQ + NBFB - NBFA;
    localparam int NUM_W = NBA + SH;
    localparam int CNT_W = $clog2(NUM_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Saturated result limits in the NBQ-bit two's-complement format.
    localparam logic [NBQ-1:0] Q_MAX_POS = {1'b0, {(NBQ-1){1'b1}}};
    localparam logic [NBQ-1:0] Q_MAX_NEG = {1'b1, {(NBQ-1){1'b0}}};

endpackage

// File: rtl/sat_trunc_fixed.sv
// Combinational sign/magnitude to saturated two's-complement converter.
// Ports:
//   i_neg  - result sign (1 = negative)
//   i_mag  - unsigned magnitude, MAG_W bits (MAG_W >= OUT_W)
//   o_q    - OUT_W-bit two's-complement value, clipped to the
//            representable range [-2^(OUT_W-1), 2^(OUT_W-1)-1]
module sat_trunc_fixed
    import divisor_fixed_pkg::*;
#(
    parameter int MAG_W = NUM_W,
    parameter int OUT_W = NBQ
) (
    input  logic             i_neg,
    input  logic [MAG_W-1:0] i_mag,
    output logic [OUT_W-1:0] o_q
);

    localparam logic [MAG_W-1:0] POS_LIM = MAG_W'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(64'd1 << (OUT_W - 1));

    // Clip the magnitude against the sign-dependent limit, then apply the sign.
    always_comb begin
        o_q = {OUT_W{1'b0}};
        if (!i_neg) begin
            if (i_mag > POS_LIM) begin
                o_q = {1'b0, {(OUT_W-1){1'b1}}};
            end else begin
                o_q = i_mag[OUT_W-1:0];
            end
        end else begin
            // A magnitude of exactly 2^(OUT_W-1) negates onto the most
            // negative code, so only strictly larger values clip.
            if (i_mag > NEG_LIM) begin
                o_q = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                o_q = (~i_mag[OUT_W-1:0]) + {{(OUT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/divisor_fixed.sv
// Sequential signed fixed-point divider, one quotient bit per cycle.
// Computes S(NBA,NBFA) / S(NBB,NBFB) -> S(NBQ,NBFQ), truncating toward zero
// and saturating; a zero divisor flags o_div_zero and returns the limit
// matching the dividend sign. Latency is constant (NUM_W+1 edges from accept).
// Ports:
//   i_clock, i_reset - clock, synchronous active-high reset
//   i_valid/o_ready  - operand handshake, accept when both high at an edge
//   i_saa_aa         - dividend, i_sbb_bb - divisor
//   o_valid          - one-cycle result strobe
//   o_sqq_qq         - quotient, o_div_zero - zero-divisor flag (both held)
module divisor_fixed
    import divisor_fixed_pkg::*;
(
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [NBA-1:0] i_saa_aa,
    input  logic [NBB-1:0] i_sbb_bb,
    output logic           o_valid,
    output logic [NBQ-1:0] o_sqq_qq,
    output logic           o_div_zero
);

    generate
        if (SH < 0) begin : g_sh_check
            $error("divisor_fixed: NBFQ + NBFB - NBFA must be non-negative");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NBB:0]     rem_q, rem_d;
    // Numerator bits shift out of the top while quotient bits shift in at
    // the bottom; after NUM_W steps the register holds the quotient magnitude.
    logic [NUM_W-1:0] nq_q, nq_d;
    logic [NBB-1:0]   b_mag_q, b_mag_d;
    logic             neg_q, neg_d;
    logic             a_neg_q, a_neg_d;
    logic             dz_q, dz_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic [NBQ-1:0]   sqq_q, sqq_d;
    logic             div_zero_q, div_zero_d;

    logic [NBA-1:0]   a_mag_s;
    logic [NBB-1:0]   b_mag_s;
    logic [NBB:0]     rem_shift_s;
    logic [NBB:0]     rem_sub_s;
    logic             fits_s;
    logic [NBQ-1:0]   sat_q_s;

    // Operand magnitudes; the most negative code maps onto 2^(N-1) unsigned.
    always_comb begin
        if (i_saa_aa[NBA-1]) begin
            a_mag_s = (~i_saa_aa) + {{(NBA-1){1'b0}}, 1'b1};
        end else begin
            a_mag_s = i_saa_aa;
        end
        if (i_sbb_bb[NBB-1]) begin
            b_mag_s = (~i_sbb_bb) + {{(NBB-1){1'b0}}, 1'b1};
        end else begin
            b_mag_s = i_sbb_bb;
        end
    end

    // One restoring-division step: shift in the next numerator bit, subtract if it fits.
    always_comb begin
        rem_shift_s = {rem_q[NBB-1:0], nq_q[NUM_W-1]};
        rem_sub_s   = rem_shift_s - {1'b0, b_mag_q};
        fits_s      = (rem_shift_s >= {1'b0, b_mag_q});
    end

    sat_trunc_fixed #(
        .MAG_W (NUM_W),
        .OUT_W (NBQ)
    ) u_sat (
        .i_neg (neg_q),
        .i_mag (nq_q),
        .o_q   (sat_q_s)
    );

    // Next-state, datapath and output-register load logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        nq_d       = nq_q;
        b_mag_d    = b_mag_q;
        neg_d      = neg_q;
        a_neg_d    = a_neg_q;
        dz_d       = dz_q;
        sqq_d      = sqq_q;
        div_zero_d = div_zero_q;
        valid_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    rem_d   = {(NBB+1){1'b0}};
                    nq_d    = NUM_W'(a_mag_s) << SH;
                    b_mag_d = b_mag_s;
                    neg_d   = i_saa_aa[NBA-1] ^ i_sbb_bb[NBB-1];
                    a_neg_d = i_saa_aa[NBA-1];
                    dz_d    = (i_sbb_bb == {NBB{1'b0}});
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                // A zero divisor makes every step "fit"; the result is
                // overridden in DONE, the steps still run for fixed latency.
                if (fits_s) begin
                    rem_d = rem_sub_s;
                end else begin
                    rem_d = rem_shift_s;
                end
                nq_d = {nq_q[NUM_W-2:0], fits_s};
                if (cnt_q == CNT_W'(NUM_W - 1)) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                if (dz_q) begin
                    sqq_d = a_neg_q ? Q_MAX_NEG : Q_MAX_POS;
                end else begin
                    sqq_d = sat_q_s;
                end
                div_zero_d = dz_q;
                valid_d    = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            rem_q      <= {(NBB+1){1'b0}};
            nq_q       <= {NUM_W{1'b0}};
            b_mag_q    <= {NBB{1'b0}};
            neg_q      <= 1'b0;
            a_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
            sqq_q      <= {NBQ{1'b0}};
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            nq_q       <= nq_d;
            b_mag_q    <= b_mag_d;
            neg_q      <= neg_d;
            a_neg_q    <= a_neg_d;
            dz_q       <= dz_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            sqq_q      <= sqq_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_sqq_qq   = sqq_q;
    assign o_div_zero = div_zero_q;

endmodule

// File: tb/tb_divisor_fixed.sv
module tb_divisor_fixed;

    localparam int LAT = 24;

    logic               clk;
    logic               rst;
    logic               valid;
    logic               ready;
    logic signed [15:0] a;
    logic signed [11:0] b;
    logic               o_valid;
    logic [10:0]        q;
    logic               dz;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [10:0] q;
        logic        dz;
        int          acc;
    } exp_t;

    exp_t sb[$];

    divisor_fixed dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_valid    (valid),
        .o_ready    (ready),
        .i_saa_aa   (a),
        .i_sbb_bb   (b),
        .o_valid    (o_valid),
        .o_sqq_qq   (q),
        .o_div_zero (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer division of |A|*2^7 by |B|, then clip.
    function automatic exp_t model(input logic signed [15:0] av, input logic signed [11:0] bv);
        exp_t e;
        int am, bm, qm;
        bit neg;
        am  = (av < 0) ? -int'(av) : int'(av);
        bm  = (bv < 0) ? -int'(bv) : int'(bv);
        neg = (av < 0) ^ (bv < 0);
        e.acc = 0;
        if (bm == 0) begin
            e.dz = 1'b1;
            e.q  = (av < 0) ? 11'h400 : 11'h3FF;
        end else begin
            e.dz = 1'b0;
            qm   = (am * 128) / bm;
            if (!neg) e.q = (qm > 1023) ? 11'h3FF : 11'(qm);
            else      e.q = (qm > 1024) ? 11'h400 : 11'(-qm);
        end
        return e;
    endfunction

    // Scoreboard: every result strobe must match the oldest accepted operation.
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", 32'(q), 32'(e.q));
                chk("div_zero", 32'(dz), 32'(e.dz));
                chk("latency", 32'(cyc - e.acc), 32'(LAT));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [15:0] av, input logic [11:0] bv);
        exp_t e;
        int guard;
        guard = 0;
        while (ready !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        chk("ready_wait", 32'(ready), 32'd1);
        a = av;
        b = bv;
        valid = 1'b1;
        e = model(av, bv);
        e.acc = cyc + 1;
        sb.push_back(e);
        step();
        valid = 1'b0;
        a = 16'($urandom);
        b = 12'($urandom);
        for (int k = 0; k < LAT; k++) begin
            chk("busy_ready", 32'(ready), 32'd0);
            chk("busy_valid", 32'(o_valid), 32'd0);
            step();
        end
        chk("done_valid", 32'(o_valid), 32'd1);
        chk("done_ready", 32'(ready), 32'd1);
        step();
        chk("valid_pulse", 32'(o_valid), 32'd0);
        chk("held_q", 32'(q), 32'(e.q));
        chk("held_dz", 32'(dz), 32'(e.dz));
    endtask

    initial begin
        int nacc;
        int guard;
        exp_t e;
        rst = 1'b1;
        valid = 1'b0;
        a = 16'sd0;
        b = 12'sd0;
        repeat (3) step();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_dz", 32'(dz), 32'd0);
        rst = 1'b0;
        step();

        do_op(16'sd8192, 12'sd1536);
        do_op(-16'sd8192, 12'sd1536);
        do_op(16'sd16384, 12'sd1024);
        do_op(16'sd16384, -12'sd2048);
        do_op(-16'sd4096, 12'sd0);
        do_op(16'sd0, 12'sd0);
        do_op(-16'sd32768, -12'sd2048);
        do_op(-16'sd32768, 12'sd2047);
        do_op(16'sd100, -12'sd3);
        for (int i = 0; i < 6; i++) begin
            do_op(16'($urandom), 12'($urandom));
        end

        // Reset 10 cycles into a calculation: aborted, no strobe.
        do_op(16'sd8192, 12'sd1536);
        a = 16'sd1000;
        b = 12'sd7;
        valid = 1'b1;
        step();
        valid = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_valid", 32'(o_valid), 32'd0);
        chk("abort_q", 32'(q), 32'd0);
        chk("abort_dz", 32'(dz), 32'd0);
        for (int k = 0; k < 40; k++) begin
            chk("abort_no_valid", 32'(o_valid), 32'd0);
            step();
        end
        do_op(-16'sd8192, 12'sd1536);

        // Back-to-back: i_valid held high with operands changing every cycle.
        nacc = 0;
        valid = 1'b1;
        for (int k = 0; k < 80; k++) begin
            a = 16'($urandom);
            b = 12'($urandom_range(0, 4095));
            if (ready === 1'b1) begin
                e = model(a, b);
                e.acc = cyc + 1;
                sb.push_back(e);
                nacc++;
            end
            step();
        end
        valid = 1'b0;
        chk("b2b_accepts", 32'(nacc), 32'd4);
        guard = 0;
        while (sb.size() != 0 && guard < 60) begin
            step();
            guard++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
